// File: rtl/tnn_pkg.sv
// Shared constants, types and helpers for the TNN column blocks.
package tnn_pkg;

   localparam int unsigned PULSE_W_DEF = 8;
   localparam int unsigned TW_DEF      = 4;

   // Wave-time value at the default counter width.
   typedef logic [TW_DEF-1:0] wave_t;

   // Number of set bits; callers zero-extend narrower vectors.
   function automatic int unsigned popcount(input logic [63:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 64; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/kwta_pick.sv
// Selects up to 'slots' candidates, lowest index first, never more than K.
module kwta_pick
   import tnn_pkg::*;
#(
   parameter int unsigned Q  = 2,
   parameter int unsigned K  = 1,
   parameter int unsigned CW = $clog2(Q + 1)
) (
   input  logic [Q-1:0]  cand,
   input  logic [CW-1:0] slots,
   output logic [Q-1:0]  acc,
   output logic [CW-1:0] n_acc
);

   localparam logic [CW-1:0] K_L = CW'(K);

   logic [CW-1:0] taken;

   // Walk candidates from index 0 upward, granting while slots remain.
   always_comb begin
      acc   = '0;
      taken = '0;
      for (int i = 0; i < int'(Q); i++) begin
         if (cand[i] && (taken < slots) && (taken < K_L)) begin
            acc[i] = 1'b1;
            taken  = taken + CW'(1);
         end
      end
      n_acc = CW'(popcount(64'(acc)));
   end

endmodule

// File: rtl/kwta_li.sv
// k-winner-take-all lateral inhibition for one TNN column.
module kwta_li
   import tnn_pkg::*;
#(
   parameter int unsigned Q       = 2,
   parameter int unsigned K       = 1,
   parameter int unsigned PULSE_W = PULSE_W_DEF,
   parameter int unsigned TW      = TW_DEF,
   parameter int unsigned T_MAX   = 15
) (
   input  logic                                 clk,
   input  logic                                 rstb,
   input  logic                                 grst,
   input  logic                                 bypass,
   input  logic [Q-1:0]                         ec_spikes,
   output logic [Q-1:0]                         li_out,
   output logic [$clog2(Q+1)-1:0]               win_cnt,
   output logic                                 first_valid,
   output logic [((Q > 1) ? $clog2(Q) : 1)-1:0] first_idx,
   output logic [TW-1:0]                        first_time
);

   localparam int unsigned CW  = $clog2(Q + 1);
   localparam int unsigned IW  = (Q > 1) ? $clog2(Q) : 1;
   localparam int unsigned PCW = $clog2(PULSE_W + 1);

   localparam logic [CW-1:0]  K_L     = CW'(K);
   localparam logic [CW-1:0]  Q_L     = CW'(Q);
   localparam logic [TW-1:0]  TMAX_L  = TW'(T_MAX);
   localparam logic [PCW-1:0] PULSE_L = PCW'(PULSE_W);

   if (K < 1 || K > Q || PULSE_W < 1 || T_MAX >= (1 << TW)) begin : g_param_check
      $error("kwta_li: illegal parameter set");
   end

   logic [Q-1:0]   ec_q;
   logic [Q-1:0]   seen;
   logic [TW-1:0]  t;
   logic [PCW-1:0] pcnt [Q];

   logic [Q-1:0]  rise;
   logic [Q-1:0]  cand;
   logic [Q-1:0]  pick_cand;
   logic [Q-1:0]  pick_acc;
   logic [CW-1:0] pick_n;
   logic [CW-1:0] slots;
   logic [Q-1:0]  acc;
   logic [CW-1:0] n_acc;
   logic [CW:0]   win_sum;
   logic [CW-1:0] win_cap;
   logic [CW-1:0] win_next;
   logic [IW-1:0] lo_idx;

   kwta_pick #(
      .Q  (Q),
      .K  (K),
      .CW (CW)
   ) u_pick (
      .cand  (pick_cand),
      .slots (slots),
      .acc   (pick_acc),
      .n_acc (pick_n)
   );

   // Candidate detection, slot budget and winner bookkeeping for this cycle.
   always_comb begin
      rise      = ec_spikes & ~ec_q;
      cand      = rise & ~seen;
      // A rise that coincides with grst belongs to no wave and is dropped.
      pick_cand = grst ? '0 : cand;
      slots     = '0;
      if (!bypass && (t <= TMAX_L) && (win_cnt < K_L)) slots = K_L - win_cnt;
      if (bypass) begin
         acc   = pick_cand;
         n_acc = CW'(popcount(64'(pick_cand)));
      end else begin
         acc   = pick_acc;
         n_acc = pick_n;
      end
      win_cap  = bypass ? Q_L : K_L;
      win_sum  = {1'b0, win_cnt} + {1'b0, n_acc};
      win_next = (win_sum > {1'b0, win_cap}) ? win_cap : win_sum[CW-1:0];
      lo_idx   = '0;
      for (int i = int'(Q) - 1; i >= 0; i--) begin
         if (acc[i]) lo_idx = IW'(i);
      end
   end

   // Wave state: edge history, seen mask, wave time, winner count and first winner.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         ec_q        <= '0;
         seen        <= '0;
         t           <= '0;
         win_cnt     <= '0;
         first_valid <= 1'b0;
         first_idx   <= '0;
         first_time  <= '0;
      end else begin
         ec_q <= ec_spikes;
         if (grst) begin
            seen        <= '0;
            t           <= '0;
            win_cnt     <= '0;
            first_valid <= 1'b0;
            first_idx   <= '0;
            first_time  <= '0;
         end else begin
            if (t != '1) t <= t + TW'(1);
            // Rejected candidates are marked too, so they stay inhibited.
            seen    <= seen | rise;
            win_cnt <= win_next;
            if (!first_valid && (acc != '0)) begin
               first_valid <= 1'b1;
               first_idx   <= lo_idx;
               first_time  <= t;
            end
         end
      end
   end

   // Per-channel pulse stretchers, loaded on acceptance and truncated by grst.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < int'(Q); i++) pcnt[i] <= '0;
      end else begin
         for (int i = 0; i < int'(Q); i++) begin
            if (grst)                pcnt[i] <= '0;
            else if (acc[i])         pcnt[i] <= PULSE_L;
            else if (pcnt[i] != '0)  pcnt[i] <= pcnt[i] - PCW'(1);
         end
      end
   end

   // A channel's output is high while its stretcher is non-zero.
   always_comb begin
      li_out = '0;
      for (int i = 0; i < int'(Q); i++) li_out[i] = (pcnt[i] != '0);
   end

endmodule

// File: tb/tb_kwta_li.sv
// Self-checking bench for kwta_li: directed scenarios plus random waves vs a wave-level model.
module tb_kwta_li;

   logic clk;
   logic rstb;

   // Instance A: Q=4, K=2, T_MAX=10
   logic       a_grst, a_bypass;
   logic [3:0] a_ec, a_li;
   logic [2:0] a_win;
   logic       a_fv;
   logic [1:0] a_fidx;
   logic [3:0] a_ftime;

   // Instance B: Q=8, K=1, T_MAX=10
   logic       b_grst, b_bypass;
   logic [7:0] b_ec, b_li;
   logic [3:0] b_win;
   logic       b_fv;
   logic [2:0] b_fidx;
   logic [3:0] b_ftime;

   int total;
   int bad;

   kwta_li #(.Q(4), .K(2), .PULSE_W(8), .TW(4), .T_MAX(10)) dut_a (
      .clk         (clk),
      .rstb        (rstb),
      .grst        (a_grst),
      .bypass      (a_bypass),
      .ec_spikes   (a_ec),
      .li_out      (a_li),
      .win_cnt     (a_win),
      .first_valid (a_fv),
      .first_idx   (a_fidx),
      .first_time  (a_ftime)
   );

   kwta_li #(.Q(8), .K(1), .PULSE_W(8), .TW(4), .T_MAX(10)) dut_b (
      .clk         (clk),
      .rstb        (rstb),
      .grst        (b_grst),
      .bypass      (b_bypass),
      .ec_spikes   (b_ec),
      .li_out      (b_li),
      .win_cnt     (b_win),
      .first_valid (b_fv),
      .first_idx   (b_fidx),
      .first_time  (b_ftime)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_wave_start();
      a_grst = 1'b1;
      a_ec   = '0;
      tick();
      a_grst = 1'b0;
   endtask

   task automatic test_reset();
      rstb = 1'b0;
      a_ec = 4'hF;
      b_ec = 8'hFF;
      repeat (3) tick();
      total++;
      if (a_li !== 4'h0 || a_win !== 3'd0 || a_fv !== 1'b0) begin
         bad++;
         $display("FAIL reset_a li=%h win=%0d fv=%b want 0/0/0", a_li, a_win, a_fv);
      end
      total++;
      if (b_li !== 8'h0 || b_win !== 4'd0 || b_fv !== 1'b0) begin
         bad++;
         $display("FAIL reset_b li=%h win=%0d fv=%b want 0/0/0", b_li, b_win, b_fv);
      end
      a_ec = '0;
      b_ec = '0;
      rstb = 1'b1;
      tick();
      // Start a pulse, then drop rstb between clock edges.
      a_wave_start();
      a_ec = 4'b0001;
      tick();
      total++;
      if (a_li !== 4'b0001) begin
         bad++;
         $display("FAIL pre_async_pulse li=%h want 1", a_li);
      end
      a_ec = '0;
      #2 rstb = 1'b0;
      #1;
      total++;
      if (a_li !== 4'h0 || a_win !== 3'd0 || a_fv !== 1'b0) begin
         bad++;
         $display("FAIL async_reset li=%h win=%0d fv=%b want 0/0/0", a_li, a_win, a_fv);
      end
      #1 rstb = 1'b1;
      tick();
   endtask

   task automatic test_k_winners();
      logic [3:0] exp;
      a_wave_start();
      for (int c = 0; c < 16; c++) begin
         a_ec    = '0;
         a_ec[2] = (c >= 3 && c <= 4);
         a_ec[0] = (c >= 5 && c <= 6);
         a_ec[1] = (c >= 6 && c <= 7);
         tick();
         exp    = '0;
         exp[2] = (c >= 3 && c <= 10);
         exp[0] = (c >= 5 && c <= 12);
         total++;
         if (a_li !== exp) begin
            bad++;
            $display("FAIL k_winners_li t=%0d got=%h want=%h", c, a_li, exp);
         end
      end
      a_ec = '0;
      total++;
      if (a_win !== 3'd2 || a_fv !== 1'b1 || a_fidx !== 2'd2 || a_ftime !== 4'd3) begin
         bad++;
         $display("FAIL k_winners_first win=%0d fv=%b idx=%0d time=%0d want 2/1/2/3",
                  a_win, a_fv, a_fidx, a_ftime);
      end
   endtask

   task automatic test_ties();
      logic [3:0] exp;
      a_wave_start();
      for (int c = 0; c < 13; c++) begin
         a_ec    = '0;
         a_ec[0] = (c >= 2 && c <= 3);
         a_ec[1] = (c >= 2 && c <= 3);
         a_ec[3] = (c >= 2 && c <= 3) || (c >= 6 && c <= 7);
         tick();
         exp = (c >= 2 && c <= 9) ? 4'b0011 : 4'b0000;
         total++;
         if (a_li !== exp) begin
            bad++;
            $display("FAIL ties_li t=%0d got=%h want=%h", c, a_li, exp);
         end
      end
      a_ec = '0;
      total++;
      if (a_win !== 3'd2 || a_fidx !== 2'd0 || a_ftime !== 4'd2) begin
         bad++;
         $display("FAIL ties_first win=%0d idx=%0d time=%0d want 2/0/2", a_win, a_fidx, a_ftime);
      end
   endtask

   task automatic test_window_and_width();
      logic [3:0] exp;
      a_wave_start();
      for (int c = 0; c < 15; c++) begin
         a_ec    = '0;
         a_ec[1] = (c >= 11 && c <= 12);
         tick();
         total++;
         if (a_li !== 4'h0) begin
            bad++;
            $display("FAIL late_spike_li t=%0d got=%h want=0", c, a_li);
         end
      end
      a_ec = '0;
      total++;
      if (a_win !== 3'd0 || a_fv !== 1'b0) begin
         bad++;
         $display("FAIL late_spike_cnt win=%0d fv=%b want 0/0", a_win, a_fv);
      end
      a_wave_start();
      for (int c = 0; c < 25; c++) begin
         a_ec    = '0;
         a_ec[0] = (c < 20);
         tick();
         exp = (c <= 7) ? 4'b0001 : 4'b0000;
         total++;
         if (a_li !== exp) begin
            bad++;
            $display("FAIL held_spike_li t=%0d got=%h want=%h", c, a_li, exp);
         end
      end
      a_ec = '0;
      total++;
      if (a_win !== 3'd1) begin
         bad++;
         $display("FAIL held_spike_cnt win=%0d want 1", a_win);
      end
   endtask

   task automatic test_grst();
      a_wave_start();
      a_ec = 4'b0001;
      repeat (3) tick();
      total++;
      if (a_li !== 4'b0001) begin
         bad++;
         $display("FAIL grst_pre li=%h want 1", a_li);
      end
      a_grst = 1'b1;
      tick();
      a_grst = 1'b0;
      total++;
      if (a_li !== 4'h0 || a_win !== 3'd0 || a_fv !== 1'b0) begin
         bad++;
         $display("FAIL grst_truncate li=%h win=%0d fv=%b want 0/0/0", a_li, a_win, a_fv);
      end
      a_ec = '0;
      tick();
      a_ec = 4'b0001;
      tick();
      total++;
      if (a_li !== 4'b0001 || a_ftime !== 4'd1 || a_fidx !== 2'd0 || a_fv !== 1'b1) begin
         bad++;
         $display("FAIL grst_new_wave li=%h time=%0d idx=%0d fv=%b want 1/1/0/1",
                  a_li, a_ftime, a_fidx, a_fv);
      end
      a_ec = '0;
      tick();
      a_grst = 1'b1;
      a_ec   = 4'b0010;
      tick();
      a_grst = 1'b0;
      total++;
      if (a_li !== 4'h0 || a_win !== 3'd0) begin
         bad++;
         $display("FAIL grst_drop li=%h win=%0d want 0/0", a_li, a_win);
      end
      a_ec = '0;
      tick();
      a_ec = 4'b0010;
      tick();
      total++;
      if (a_li !== 4'b0010 || a_win !== 3'd1 || a_fidx !== 2'd1) begin
         bad++;
         $display("FAIL grst_rerise li=%h win=%0d idx=%0d want 2/1/1", a_li, a_win, a_fidx);
      end
      a_ec = '0;
   endtask

   task automatic test_bypass();
      a_bypass = 1'b1;
      a_wave_start();
      for (int c = 0; c < 13; c++) begin
         a_ec = (c == 12) ? 4'hF : 4'h0;
         tick();
      end
      a_ec = '0;
      total++;
      if (a_li !== 4'hF || a_win !== 3'd4 || a_fidx !== 2'd0 || a_ftime !== 4'd12) begin
         bad++;
         $display("FAIL bypass li=%h win=%0d idx=%0d time=%0d want F/4/0/12",
                  a_li, a_win, a_fidx, a_ftime);
      end
      a_bypass = 1'b0;
      tick();
   endtask

   // Random waves on instance B, predicted per wave from rise times alone.
   task automatic test_random();
      int  has [8];
      int  r [8];
      int  wd [8];
      int  rr [8];
      int  acc [8];
      int  n_acc, f_idx, f_time, byp;
      logic [7:0] ec, exp;
      for (int w = 0; w < 1000; w++) begin
         byp = ($urandom_range(0, 3) == 0) ? 1 : 0;
         for (int ch = 0; ch < 8; ch++) begin
            has[ch] = ($urandom_range(0, 3) != 0) ? 1 : 0;
            r[ch]   = int'($urandom_range(0, 14));
            wd[ch]  = int'($urandom_range(1, 3));
            rr[ch]  = r[ch] + wd[ch] + 1 + int'($urandom_range(0, 3));
            acc[ch] = 0;
         end
         n_acc  = 0;
         f_idx  = -1;
         f_time = 0;
         for (int tm = 0; tm < 15; tm++) begin
            for (int ch = 0; ch < 8; ch++) begin
               if (has[ch] != 0 && r[ch] == tm &&
                   (byp != 0 || (tm <= 10 && n_acc < 1))) begin
                  acc[ch] = 1;
                  n_acc++;
                  if (f_idx < 0) begin
                     f_idx  = ch;
                     f_time = tm;
                  end
               end
            end
         end
         b_bypass = byp[0];
         b_grst   = 1'b1;
         b_ec     = '0;
         tick();
         b_grst = 1'b0;
         for (int c = 0; c < 25; c++) begin
            ec  = '0;
            exp = '0;
            for (int ch = 0; ch < 8; ch++) begin
               if (has[ch] != 0)
                  ec[ch] = (c >= r[ch] && c < r[ch] + wd[ch]) || (c == rr[ch]);
               if (acc[ch] != 0) exp[ch] = (c >= r[ch] && c <= r[ch] + 7);
            end
            b_ec = ec;
            tick();
            total++;
            if (b_li !== exp) begin
               bad++;
               $display("FAIL rand_li wave=%0d t=%0d got=%h want=%h", w, c, b_li, exp);
            end
         end
         b_ec = '0;
         total++;
         if (b_win !== 4'(n_acc) || b_fv !== (f_idx >= 0)) begin
            bad++;
            $display("FAIL rand_cnt wave=%0d win=%0d fv=%b want %0d/%0d",
                     w, b_win, b_fv, n_acc, (f_idx >= 0));
         end
         if (f_idx >= 0) begin
            total++;
            if (b_fidx !== 3'(f_idx) || b_ftime !== 4'(f_time)) begin
               bad++;
               $display("FAIL rand_first wave=%0d idx=%0d time=%0d want %0d/%0d",
                        w, b_fidx, b_ftime, f_idx, f_time);
            end
         end
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rstb     = 1'b0;
      a_grst   = 1'b0;
      a_bypass = 1'b0;
      a_ec     = '0;
      b_grst   = 1'b0;
      b_bypass = 1'b0;
      b_ec     = '0;
      test_reset();
      test_k_winners();
      test_ties();
      test_window_and_width();
      test_grst();
      test_bypass();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
